litho_exposure_sequencer: RTL and testbench

Lot-level master controller that drives the lithography submodules (wafer/reticle loaders, wafer/reticle stages, light source, environment control) through a full exposure lot. It is the initiator side of the level cmd/ready handshake those submodules respond to. It sits at scanner top level between the host start/abort interface and the six submodules. Each step has a timeout watchdog and reports failures with an error code.

---
 rtl/litho_exposure_sequencer.sv | 370 +++++++++++++++++++++++++++++++++++++
 tb/tb_litho_exposure_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/litho_exposure_sequencer.sv
// litho_exposure_sequencer: lot-level master driving loaders, stages and source.
// Optional SEQ_RETRY_EN: one retry per step after an ACTIVE-phase timeout.
module litho_exposure_sequencer #(
  parameter int NUM_WAFERS   = 2,
  parameter int NUM_FIELDS   = 4,
  parameter int STEP_TIMEOUT = 31,
  parameter int ENV_TIMEOUT  = 63
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic       env_ok,
  input  logic       wl_ready,
  input  logic       rl_ready,
  input  logic       ws_done,
  input  logic       rs_done,
  input  logic       source_on,
  output logic       wl_cmd_load,
  output logic       wl_cmd_unload,
  output logic       rl_cmd_load,
  output logic       rl_cmd_unload,
  output logic       ws_cmd_calib,
  output logic       ws_cmd_align,
  output logic       ws_cmd_scan,
  output logic       rs_cmd_calib,
  output logic       rs_cmd_sync,
  output logic       ls_cmd_active,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [3:0] err_code,
  output logic [7:0] wafer_idx,
  output logic [7:0] field_idx
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_WAIT_ENV,
    S_RL_LOAD,
    S_CALIB,
    S_WL_LOAD,
    S_ALIGN,
    S_EXPOSE,
    S_WL_UNLOAD,
    S_RL_UNLOAD,
    S_DONE,
    S_ERROR,
    S_RETRY
  } state_t;

  localparam logic [7:0] STEP_LIM = 8'(STEP_TIMEOUT);
  localparam logic [7:0] ENV_LIM  = 8'(ENV_TIMEOUT);
  localparam logic [7:0] W_LAST   = 8'(NUM_WAFERS - 1);
  localparam logic [7:0] F_LAST   = 8'(NUM_FIELDS - 1);

  localparam logic [3:0] E_ENV    = 4'd1;
  localparam logic [3:0] E_RL_LD  = 4'd2;
  localparam logic [3:0] E_WL_LD  = 4'd3;
  localparam logic [3:0] E_CALIB  = 4'd4;
  localparam logic [3:0] E_ALIGN  = 4'd5;
  localparam logic [3:0] E_EXPOSE = 4'd6;
  localparam logic [3:0] E_SOURCE = 4'd7;
  localparam logic [3:0] E_WL_UL  = 4'd8;
  localparam logic [3:0] E_RL_UL  = 4'd9;
  localparam logic [3:0] E_ABORT  = 4'd10;
  localparam logic [3:0] E_ENVLOS = 4'd11;

  localparam int C_WL_LD = 0;
  localparam int C_WL_UL = 1;
  localparam int C_RL_LD = 2;
  localparam int C_RL_UL = 3;
  localparam int C_WS_CA = 4;
  localparam int C_WS_AL = 5;
  localparam int C_WS_SC = 6;
  localparam int C_RS_CA = 7;
  localparam int C_RS_SY = 8;
  localparam int C_LS_AC = 9;

  state_t      state_q, state_d;
  logic        act_q, act_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        ws_seen_q, ws_seen_d;
  logic        rs_seen_q, rs_seen_d;
  logic [7:0]  wafer_q, wafer_d;
  logic [7:0]  field_q, field_d;
  logic [3:0]  code_q, code_d;

  logic        act_met;
  logic        rel_ok;
  logic [3:0]  step_code;
  logic [7:0]  lim;
  logic        run;
  logic        env_lost;
  logic        src_fault;
  logic        enter;
  logic        flt;
  logic [3:0]  flt_code;
  logic        retry_ok;
  state_t      resume_st;

  logic [9:0]  cmd_d, cmd_q;
  logic        busy_d, busy_q;
  logic        done_d, done_q;
  logic        error_d, error_q;
  logic [3:0]  err_d, err_q;

`ifdef SEQ_RETRY_EN
  logic        retry_q;
  state_t      ret_st_q;

  assign retry_ok  = !retry_q && (state_q != S_WAIT_ENV);
  assign resume_st = ret_st_q;

  // Remember the step being retried; forget it once a step completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retry_q  <= 1'b0;
      ret_st_q <= S_IDLE;
    end else if (state_q != S_RETRY && state_d == S_RETRY) begin
      retry_q  <= 1'b1;
      ret_st_q <= state_q;
    end else if ((!act_q && act_d) || state_d == S_WAIT_ENV) begin
      retry_q  <= 1'b0;
    end
  end
`else
  assign retry_ok  = 1'b0;
  assign resume_st = S_IDLE;
`endif

  // State register with phase, watchdog, response latches and indices.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      act_q     <= 1'b0;
      cnt_q     <= '0;
      ws_seen_q <= 1'b0;
      rs_seen_q <= 1'b0;
      wafer_q   <= '0;
      field_q   <= '0;
      code_q    <= '0;
    end else begin
      state_q   <= state_d;
      act_q     <= act_d;
      cnt_q     <= cnt_d;
      ws_seen_q <= ws_seen_d;
      rs_seen_q <= rs_seen_d;
      wafer_q   <= wafer_d;
      field_q   <= field_d;
      code_q    <= code_d;
    end
  end

  // Next-state: step decode, fault priority, handshake phases, lot walk.
  always_comb begin
    act_met   = 1'b0;
    rel_ok    = 1'b1;
    step_code = 4'd0;
    lim       = STEP_LIM;
    case (state_q)
      S_WAIT_ENV: begin
        act_met   = env_ok;
        step_code = E_ENV;
        lim       = ENV_LIM;
      end
      S_RL_LOAD: begin
        act_met   = rl_ready;
        rel_ok    = !rl_ready;
        step_code = E_RL_LD;
      end
      S_CALIB: begin
        act_met   = (ws_seen_q | ws_done) & (rs_seen_q | rs_done);
        rel_ok    = !ws_done && !rs_done;
        step_code = E_CALIB;
      end
      S_WL_LOAD: begin
        act_met   = wl_ready;
        rel_ok    = !wl_ready;
        step_code = E_WL_LD;
      end
      S_ALIGN: begin
        act_met   = ws_done;
        rel_ok    = !ws_done;
        step_code = E_ALIGN;
      end
      S_EXPOSE: begin
        act_met   = (ws_seen_q | ws_done) & (rs_seen_q | rs_done);
        rel_ok    = !ws_done && !rs_done && !source_on;
        step_code = E_EXPOSE;
      end
      S_WL_UNLOAD: begin
        act_met   = wl_ready;
        rel_ok    = !wl_ready;
        step_code = E_WL_UL;
      end
      S_RL_UNLOAD: begin
        act_met   = rl_ready;
        rel_ok    = !rl_ready;
        step_code = E_RL_UL;
      end
      default: ;
    endcase

    run = !(state_q inside {S_IDLE, S_DONE, S_ERROR});
    env_lost  = run && (state_q != S_WAIT_ENV) && !env_ok;
    src_fault = (state_q == S_EXPOSE) && act_q &&
                (cnt_q != 8'd0) && !source_on;

    state_d   = state_q;
    act_d     = act_q;
    cnt_d     = run ? cnt_q + 8'd1 : cnt_q;
    ws_seen_d = ws_seen_q | ws_done;
    rs_seen_d = rs_seen_q | rs_done;
    wafer_d   = wafer_q;
    field_d   = field_q;
    code_d    = code_q;
    enter     = 1'b0;
    flt       = 1'b0;
    flt_code  = 4'd0;

    if (!run) begin
      if (start && state_q == S_ERROR) begin
        state_d = S_IDLE;
        code_d  = 4'd0;
      end else if (start) begin
        state_d = S_WAIT_ENV;
        act_d   = 1'b1;
        enter   = 1'b1;
        wafer_d = '0;
        field_d = '0;
        code_d  = 4'd0;
      end
    end else if (abort) begin
      flt      = 1'b1;
      flt_code = E_ABORT;
    end else if (env_lost) begin
      flt      = 1'b1;
      flt_code = E_ENVLOS;
    end else if (src_fault) begin
      flt      = 1'b1;
      flt_code = E_SOURCE;
    end else if (state_q == S_RETRY) begin
      if (cnt_q == 8'd1) begin
        state_d = resume_st;
        act_d   = 1'b1;
        enter   = 1'b1;
      end
    end else if (act_q) begin
      if (act_met) begin
        enter = 1'b1;
        if (state_q == S_WAIT_ENV) state_d = S_RL_LOAD;
        else act_d = 1'b0;
      end else if (cnt_q == lim) begin
        if (retry_ok) begin
          state_d = S_RETRY;
          enter   = 1'b1;
        end else begin
          flt      = 1'b1;
          flt_code = step_code;
        end
      end
    end else begin
      if (rel_ok) begin
        act_d = 1'b1;
        enter = 1'b1;
        case (state_q)
          S_RL_LOAD: state_d = S_CALIB;
          S_CALIB:   state_d = S_WL_LOAD;
          S_WL_LOAD: state_d = S_ALIGN;
          S_ALIGN:   state_d = S_EXPOSE;
          S_EXPOSE: begin
            if (field_q == F_LAST) begin
              field_d = '0;
              state_d = S_WL_UNLOAD;
            end else begin
              field_d = field_q + 8'd1;
            end
          end
          S_WL_UNLOAD: begin
            if (wafer_q < W_LAST) begin
              wafer_d = wafer_q + 8'd1;
              state_d = S_WL_LOAD;
            end else begin
              state_d = S_RL_UNLOAD;
            end
          end
          S_RL_UNLOAD: state_d = S_DONE;
          default: ;
        endcase
      end else if (cnt_q == lim) begin
        flt      = 1'b1;
        flt_code = step_code;
      end
    end

    if (flt) begin
      state_d = S_ERROR;
      code_d  = flt_code;
    end
    if (enter) begin
      cnt_d     = '0;
      ws_seen_d = 1'b0;
      rs_seen_d = 1'b0;
    end
  end

  // Output decode of the upcoming state so outputs line up with it.
  always_comb begin
    cmd_d = '0;
    if (act_d) begin
      case (state_d)
        S_RL_LOAD:   cmd_d[C_RL_LD] = 1'b1;
        S_RL_UNLOAD: cmd_d[C_RL_UL] = 1'b1;
        S_WL_LOAD:   cmd_d[C_WL_LD] = 1'b1;
        S_WL_UNLOAD: cmd_d[C_WL_UL] = 1'b1;
        S_ALIGN:     cmd_d[C_WS_AL] = 1'b1;
        S_CALIB: begin
          cmd_d[C_WS_CA] = 1'b1;
          cmd_d[C_RS_CA] = 1'b1;
        end
        S_EXPOSE: begin
          cmd_d[C_WS_SC] = 1'b1;
          cmd_d[C_RS_SY] = 1'b1;
          cmd_d[C_LS_AC] = 1'b1;
        end
        default: ;
      endcase
    end
    busy_d  = !(state_d inside {S_IDLE, S_DONE, S_ERROR});
    done_d  = (state_d == S_DONE);
    error_d = (state_d == S_ERROR);
    err_d   = error_d ? code_d : 4'd0;
  end

  // Registered outputs; reset drops every command immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      err_q   <= '0;
    end else begin
      cmd_q   <= cmd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
      err_q   <= err_d;
    end
  end

  assign wl_cmd_load   = cmd_q[C_WL_LD];
  assign wl_cmd_unload = cmd_q[C_WL_UL];
  assign rl_cmd_load   = cmd_q[C_RL_LD];
  assign rl_cmd_unload = cmd_q[C_RL_UL];
  assign ws_cmd_calib  = cmd_q[C_WS_CA];
  assign ws_cmd_align  = cmd_q[C_WS_AL];
  assign ws_cmd_scan   = cmd_q[C_WS_SC];
  assign rs_cmd_calib  = cmd_q[C_RS_CA];
  assign rs_cmd_sync   = cmd_q[C_RS_SY];
  assign ls_cmd_active = cmd_q[C_LS_AC];
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign err_code      = err_q;
  assign wafer_idx     = wafer_q;
  assign field_idx     = field_q;

endmodule

// File: tb/tb_litho_exposure_sequencer.sv
// tb_litho_exposure_sequencer: directed lots against latency-model responders.
// Terminal results are scoreboarded; SEQ_RETRY_EN adds the retry scenarios.
module tb_litho_exposure_sequencer;

  localparam int NW     = 2;
  localparam int NF     = 4;
  localparam int STEP_T = 31;
  localparam int ENV_T  = 63;
`ifdef SEQ_RETRY_EN
  localparam int RL_FAULT_CYC = 2 * STEP_T + 4;
`else
  localparam int RL_FAULT_CYC = STEP_T + 1;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic env_ok, wl_ready, rl_ready, ws_done, rs_done, source_on;
  logic wl_cmd_load, wl_cmd_unload, rl_cmd_load, rl_cmd_unload;
  logic ws_cmd_calib, ws_cmd_align, ws_cmd_scan;
  logic rs_cmd_calib, rs_cmd_sync, ls_cmd_active;
  logic busy, done, error;
  logic [3:0] err_code;
  logic [7:0] wafer_idx, field_idx;

  logic env_kill = 1'b0;
  logic wl_kill  = 1'b0;
  logic rl_kill  = 1'b0;
  logic src_kill = 1'b0;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string      tag;
    logic       dn;
    logic       er;
    logic [3:0] code;
    logic [7:0] wf;
    logic [7:0] fd;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  litho_exposure_sequencer #(
    .NUM_WAFERS(NW), .NUM_FIELDS(NF),
    .STEP_TIMEOUT(STEP_T), .ENV_TIMEOUT(ENV_T)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .env_ok(env_ok), .wl_ready(wl_ready), .rl_ready(rl_ready),
    .ws_done(ws_done), .rs_done(rs_done), .source_on(source_on),
    .wl_cmd_load(wl_cmd_load), .wl_cmd_unload(wl_cmd_unload),
    .rl_cmd_load(rl_cmd_load), .rl_cmd_unload(rl_cmd_unload),
    .ws_cmd_calib(ws_cmd_calib), .ws_cmd_align(ws_cmd_align),
    .ws_cmd_scan(ws_cmd_scan), .rs_cmd_calib(rs_cmd_calib),
    .rs_cmd_sync(rs_cmd_sync), .ls_cmd_active(ls_cmd_active),
    .busy(busy), .done(done), .error(error), .err_code(err_code),
    .wafer_idx(wafer_idx), .field_idx(field_idx)
  );

  // Responder models: response follows command after a fixed latency.
  logic wl_c, rl_c, ws_c, rs_c, ls_c;
  assign wl_c = wl_cmd_load | wl_cmd_unload;
  assign rl_c = rl_cmd_load | rl_cmd_unload;
  assign ws_c = ws_cmd_calib | ws_cmd_align | ws_cmd_scan;
  assign rs_c = rs_cmd_calib | rs_cmd_sync;
  assign ls_c = ls_cmd_active;

  logic [7:0] n_env, n_wl, n_rl, n_ws, n_rs, n_ls;
  initial begin
    n_env = 0; n_wl = 0; n_rl = 0; n_ws = 0; n_rs = 0; n_ls = 0;
  end

  function automatic logic [7:0] inc(input logic act, input logic [7:0] v);
    if (!act) return 8'd0;
    return (v == 8'hff) ? v : v + 8'd1;
  endfunction

  always @(posedge clk) begin
    n_env <= inc(busy, n_env);
    n_wl  <= inc(wl_c, n_wl);
    n_rl  <= inc(rl_c, n_rl);
    n_ws  <= inc(ws_c, n_ws);
    n_rs  <= inc(rs_c, n_rs);
    n_ls  <= inc(ls_c, n_ls);
  end

  assign env_ok    = (n_env >= 8'd11) && !env_kill;
  assign wl_ready  = wl_c && (n_wl >= 8'd5) && !wl_kill;
  assign rl_ready  = rl_c && (n_rl >= 8'd4) && !rl_kill;
  assign ws_done   = ws_c && (n_ws >= 8'd7);
  assign rs_done   = rs_c && (n_rs >= 8'd7);
  assign source_on = ls_c && (n_ls >= 8'd1) && !src_kill;

  // Monitors: EXPOSE handshake count and cross-step command overlap.
  int n_expose  = 0;
  int n_overlap = 0;
  logic scan_prev = 1'b0;
  logic [2:0] grp;
  assign grp = {2'b0, wl_c} + {2'b0, rl_c} +
               {2'b0, ws_cmd_calib | rs_cmd_calib} +
               {2'b0, ws_cmd_align} +
               {2'b0, ws_cmd_scan | rs_cmd_sync | ls_cmd_active};

  always @(negedge clk) begin
    scan_prev <= ws_cmd_scan;
    if (ws_cmd_scan && !scan_prev) n_expose <= n_expose + 1;
    if (grp > 3'd1) n_overlap <= n_overlap + 1;
  end

  logic [9:0] cmds;
  assign cmds = {wl_cmd_load, wl_cmd_unload, rl_cmd_load, rl_cmd_unload,
                 ws_cmd_calib, ws_cmd_align, ws_cmd_scan,
                 rs_cmd_calib, rs_cmd_sync, ls_cmd_active};

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic start_lot(input exp_t e);
    sb.push_back(e);
    pulse_start();
  endtask

  task automatic wait_term(input string tag);
    exp_t e;
    for (int i = 0; i < 2000 && !(done || error); i++) @(negedge clk);
    chk({tag, ".term"}, 32'(done | error), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({e.tag, ".done"},  32'(done),      32'(e.dn));
      chk({e.tag, ".error"}, 32'(error),     32'(e.er));
      chk({e.tag, ".code"},  32'(err_code),  32'(e.code));
      chk({e.tag, ".wafer"}, 32'(wafer_idx), 32'(e.wf));
      chk({e.tag, ".field"}, 32'(field_idx), 32'(e.fd));
    end
  endtask

  initial begin
    int n;
    int m;
    int ex0;

    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset.cmds", 32'(cmds), 32'd0);
    chk("reset.flags", 32'({busy, done, error, err_code}), 32'd0);
    chk("reset.idx", 32'({wafer_idx, field_idx}), 32'd0);
    reset = 1'b0;

    // Nominal lot, with a stray start mid-run that must be ignored.
    ex0 = n_expose;
    start_lot('{"nominal", 1'b1, 1'b0, 4'd0, 8'd1, 8'd0});
    chk("nominal.busy", 32'(busy), 32'd1);
    repeat (30) @(negedge clk);
    pulse_start();
    wait_term("nominal");
    chk("nominal.expose", 32'(n_expose - ex0), 32'(NW * NF));
    chk("nominal.overlap", 32'(n_overlap), 32'd0);

    // rl_ready held low, started straight from DONE.
    rl_kill = 1'b1;
    start_lot('{"rl_to", 1'b0, 1'b1, 4'd2, 8'd0, 8'd0});
    chk("rl_to.restart", 32'({busy, done}), 32'b10);
    for (int i = 0; i < 200 && !rl_cmd_load; i++) @(negedge clk);
    chk("rl_to.cmd", 32'(rl_cmd_load), 32'd1);
    for (n = 0; n < 200 && !error; n++) @(negedge clk);
    chk("rl_to.cycles", 32'(n), 32'(RL_FAULT_CYC));
    chk("rl_to.cmds", 32'(cmds), 32'd0);
    wait_term("rl_to");
    rl_kill = 1'b0;
    pulse_start();
    chk("rl_to.clear", 32'({busy, error, err_code}), 32'd0);

    // Source drops during the third field of wafer 0.
    start_lot('{"src", 1'b0, 1'b1, 4'd7, 8'd0, 8'd2});
    for (int i = 0; i < 2000 && !(ls_cmd_active && field_idx == 8'd2);
         i++) @(negedge clk);
    chk("src.reach", 32'(field_idx), 32'd2);
    src_kill = 1'b1;
    for (n = 0; n < 10 && !error; n++) @(negedge clk);
    chk("src.cycles", 32'(n), 32'd2);
    wait_term("src");
    src_kill = 1'b0;
    pulse_start();

    // Abort in ALIGN of wafer 1, same cycle ws_done rises.
    start_lot('{"abort", 1'b0, 1'b1, 4'd10, 8'd1, 8'd0});
    for (int i = 0; i < 2000 &&
         !(ws_cmd_align && ws_done && wafer_idx == 8'd1); i++)
      @(negedge clk);
    chk("abort.reach", 32'({ws_cmd_align, ws_done}), 32'b11);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort.err", 32'({error, err_code}), 32'h1a);
    chk("abort.noscan", 32'(cmds), 32'd0);
    wait_term("abort");
    pulse_start();
    chk("abort.clear", 32'({busy, error, err_code}), 32'd0);

    // env_ok lost during CALIB.
    start_lot('{"envlos", 1'b0, 1'b1, 4'd11, 8'd0, 8'd0});
    for (int i = 0; i < 500 && !ws_cmd_calib; i++) @(negedge clk);
    env_kill = 1'b1;
    wait_term("envlos");
    env_kill = 1'b0;
    pulse_start();

    // Asynchronous reset mid-EXPOSE.
    pulse_start();
    for (int i = 0; i < 2000 && !ws_cmd_scan; i++) @(negedge clk);
    chk("arst.scan", 32'(ws_cmd_scan), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("arst.cmds", 32'(cmds), 32'd0);
    chk("arst.flags", 32'({busy, done, error, err_code}), 32'd0);
    @(negedge clk);
    reset = 1'b0;

`ifdef SEQ_RETRY_EN
    // wl_ready missing once: two idle cycles then a successful retry.
    wl_kill = 1'b1;
    start_lot('{"retry1", 1'b1, 1'b0, 4'd0, 8'd1, 8'd0});
    for (int i = 0; i < 500 && !wl_cmd_load; i++) @(negedge clk);
    for (n = 0; n < 200 && wl_cmd_load; n++) @(negedge clk);
    chk("retry1.drop", 32'(n), 32'(STEP_T + 1));
    wl_kill = 1'b0;
    for (m = 0; m < 20 && !wl_cmd_load; m++) @(negedge clk);
    chk("retry1.gap", 32'(m), 32'd2);
    wait_term("retry1");

    // wl_ready missing on both attempts.
    wl_kill = 1'b1;
    start_lot('{"retry2", 1'b0, 1'b1, 4'd3, 8'd0, 8'd0});
    wait_term("retry2");
    wl_kill = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
